bf_expand_sched: RTL and testbench

//  Sequences the feistel encrypt core through one bcrypt ExpandKey/Expand0 pass: 521 chained block

---
 rtl/bf_expand_sched_pkg.sv | 41 ++++
 rtl/bf_expand_sched_if.sv | 32 +++
 rtl/bf_expand_sched_addr.sv | 37 +++
 rtl/bf_expand_sched.sv | 190 +++++++++++++++++++
 tb/tb_bf_expand_sched.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_expand_sched_pkg.sv
// -----------------------------------------------------------------------------
// bf_expand_sched_pkg
// Shared constants, state encoding and the salt word-select helper for the
// bcrypt ExpandKey/Expand0 scheduler.
// -----------------------------------------------------------------------------
package bf_expand_sched_pkg;

  // SRAM word address of P[0] and S[0]
  localparam logic [11:0] P_BASE = 12'd4000;
  localparam logic [11:0] S_BASE = 12'd0;

  // Block encryptions per pass: 9 cover P[0..17], 512 cover S[0..1023]
  localparam int unsigned N_BLOCKS = 521;
  localparam int unsigned BLK_W    = 10;

  localparam logic [BLK_W-1:0] P_BLOCKS = 10'd9;
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(N_BLOCKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WR_L  = 3'd4,
    ST_WR_R  = 3'd5,
    ST_FIN   = 3'd6
  } sched_state_t;

  // Salt word select: word0 is the most significant 32 bits
  function automatic logic [31:0] salt_word(input logic [127:0] salt, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = salt[127:96];
      2'd1:    w = salt[95:64];
      2'd2:    w = salt[63:32];
      default: w = salt[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bf_expand_sched_if.sv
// -----------------------------------------------------------------------------
// bf_expand_sched_if
// Feistel handshake plus SRAM write-side bus of the expand scheduler.
//   fe_start/fe_L/fe_R          scheduler -> feistel block request
//   fe_resultL/fe_resultR/fe_done feistel -> scheduler completion
//   sram_sel_fe                 SRAM A/B mux select (1 = feistel reads)
//   wr_addr/wr_data/wr_cs_l/wr_we_l  mirrored SRAM write port
// master = scheduler side, slave = feistel/SRAM side.
// -----------------------------------------------------------------------------
interface bf_expand_sched_if;
  logic        fe_start;
  logic [31:0] fe_L;
  logic [31:0] fe_R;
  logic [31:0] fe_resultL;
  logic [31:0] fe_resultR;
  logic        fe_done;
  logic        sram_sel_fe;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_cs_l;
  logic        wr_we_l;

  modport master (
    output fe_start, fe_L, fe_R, sram_sel_fe, wr_addr, wr_data, wr_cs_l, wr_we_l,
    input  fe_resultL, fe_resultR, fe_done
  );

  modport slave (
    input  fe_start, fe_L, fe_R, sram_sel_fe, wr_addr, wr_data, wr_cs_l, wr_we_l,
    output fe_resultL, fe_resultR, fe_done
  );
endinterface

// File: rtl/bf_expand_sched_addr.sv
// -----------------------------------------------------------------------------
// bf_expand_sched_addr
// Maps the block index to the SRAM word address of its left half and flags
// the final block of the pass.
//   blk   in  10  block index 0..520
//   addr  out 12  P_BASE+2*blk for blk<9, else S_BASE+2*(blk-9)
//   last  out 1   blk is the final block
// -----------------------------------------------------------------------------
module bf_expand_sched_addr
  import bf_expand_sched_pkg::*;
(
  input  logic [BLK_W-1:0] blk,
  output logic [11:0]      addr,
  output logic             last
);

  logic [11:0]      base_s;
  logic [BLK_W-1:0] blk_off_s;

  // Select the table (P or S) and the block offset within it
  always_comb begin
    base_s    = P_BASE;
    blk_off_s = blk;
    if (blk < P_BLOCKS) begin
      base_s    = P_BASE;
      blk_off_s = blk;
    end else begin
      base_s    = S_BASE;
      blk_off_s = blk - P_BLOCKS;
    end
    // Two words per block; in-range values never wrap 12 bits
    addr = base_s + {1'b0, blk_off_s, 1'b0};
  end

  assign last = (blk == LAST_BLK);

endmodule

// File: rtl/bf_expand_sched.sv
// -----------------------------------------------------------------------------
// bf_expand_sched
// Runs one bcrypt ExpandKey/Expand0 pass: 521 chained feistel encryptions
// whose outputs overwrite P[0..17] then S[0..1023]. Owns the SRAM write side
// and hands the SRAM read ports to feistel while a block is being encrypted.
//   clk, reset_l   clock, async active-low reset
//   start          begin a pass (sampled only when idle)
//   use_salt       XOR salt words into the chain before each block
//   salt[127:0]    word0=[127:96] .. word3=[31:0], stable while busy
//   busy           pass in progress
//   done           one-cycle pulse after the last write
//   sched_bus      feistel handshake + SRAM write port (master side)
// All outputs are registered.
// -----------------------------------------------------------------------------
module bf_expand_sched
  import bf_expand_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset_l,
  input  logic               start,
  input  logic               use_salt,
  input  logic [127:0]       salt,
  output logic               busy,
  output logic               done,
  bf_expand_sched_if.master  sched_bus
);

  sched_state_t     state_r, state_s;
  logic [BLK_W-1:0] blk_r, blk_s;
  logic [31:0]      cl_r, cl_s, cr_r, cr_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             fe_start_r, fe_start_s;
  logic [31:0]      fe_l_r, fe_l_s, fe_r_r, fe_r_s;
  logic             sel_fe_r, sel_fe_s;
  logic [11:0]      wr_addr_r, wr_addr_s;
  logic [31:0]      wr_data_r, wr_data_s;
  logic             wr_cs_l_r, wr_cs_l_s;
  logic             wr_we_l_r, wr_we_l_s;
  logic [31:0]      salt_l_s, salt_r_s;
  logic [11:0]      addr_s;
  logic             last_s;

  bf_expand_sched_addr u_addr (
    .blk  (blk_r),
    .addr (addr_s),
    .last (last_s)
  );

  // Salt words for this block: even blocks take words 0/1, odd blocks 2/3
  always_comb begin
    salt_l_s = 32'd0;
    salt_r_s = 32'd0;
    if (use_salt) begin
      salt_l_s = salt_word(salt, {blk_r[0], 1'b0});
      salt_r_s = salt_word(salt, {blk_r[0], 1'b1});
    end else begin
      salt_l_s = 32'd0;
      salt_r_s = 32'd0;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_s    = state_r;
    blk_s      = blk_r;
    cl_s       = cl_r;
    cr_s       = cr_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    fe_start_s = 1'b0;
    fe_l_s     = fe_l_r;
    fe_r_s     = fe_r_r;
    sel_fe_s   = 1'b0;
    wr_addr_s  = wr_addr_r;
    wr_data_s  = wr_data_r;
    wr_cs_l_s  = 1'b1;
    wr_we_l_s  = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_LOAD;
          blk_s   = '0;
          cl_s    = 32'd0;
          cr_s    = 32'd0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Block input is registered here and held until the next LOAD
        fe_l_s     = cl_r ^ salt_l_s;
        fe_r_s     = cr_r ^ salt_r_s;
        fe_start_s = 1'b1;
        sel_fe_s   = 1'b1;
        state_s    = ST_START;
      end
      ST_START: begin
        sel_fe_s = 1'b1;
        state_s  = ST_WAIT;
      end
      ST_WAIT: begin
        if (sched_bus.fe_done) begin
          // Release the SRAM in the same edge the first write strobe rises
          cl_s      = sched_bus.fe_resultL;
          cr_s      = sched_bus.fe_resultR;
          wr_addr_s = addr_s;
          wr_data_s = sched_bus.fe_resultL;
          wr_cs_l_s = 1'b0;
          wr_we_l_s = 1'b0;
          state_s   = ST_WR_L;
        end else begin
          sel_fe_s = 1'b1;
        end
      end
      ST_WR_L: begin
        wr_addr_s = addr_s + 12'd1;
        wr_data_s = cr_r;
        wr_cs_l_s = 1'b0;
        wr_we_l_s = 1'b0;
        state_s   = ST_WR_R;
      end
      ST_WR_R: begin
        if (last_s) begin
          done_s  = 1'b1;
          state_s = ST_FIN;
        end else begin
          blk_s   = blk_r + 10'd1;
          state_s = ST_LOAD;
        end
      end
      ST_FIN: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, chain and output registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r    <= ST_IDLE;
      blk_r      <= '0;
      cl_r       <= 32'd0;
      cr_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fe_start_r <= 1'b0;
      fe_l_r     <= 32'd0;
      fe_r_r     <= 32'd0;
      sel_fe_r   <= 1'b0;
      wr_addr_r  <= 12'd0;
      wr_data_r  <= 32'd0;
      wr_cs_l_r  <= 1'b1;
      wr_we_l_r  <= 1'b1;
    end else begin
      state_r    <= state_s;
      blk_r      <= blk_s;
      cl_r       <= cl_s;
      cr_r       <= cr_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      fe_start_r <= fe_start_s;
      fe_l_r     <= fe_l_s;
      fe_r_r     <= fe_r_s;
      sel_fe_r   <= sel_fe_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      wr_cs_l_r  <= wr_cs_l_s;
      wr_we_l_r  <= wr_we_l_s;
    end
  end

  assign busy                  = busy_r;
  assign done                  = done_r;
  assign sched_bus.fe_start    = fe_start_r;
  assign sched_bus.fe_L        = fe_l_r;
  assign sched_bus.fe_R        = fe_r_r;
  assign sched_bus.sram_sel_fe = sel_fe_r;
  assign sched_bus.wr_addr     = wr_addr_r;
  assign sched_bus.wr_data     = wr_data_r;
  assign sched_bus.wr_cs_l     = wr_cs_l_r;
  assign sched_bus.wr_we_l     = wr_we_l_r;

endmodule

// File: tb/tb_bf_expand_sched.sv
// -----------------------------------------------------------------------------
// tb_bf_expand_sched
// Self-checking bench for bf_expand_sched. A feistel stub returns
// {L+1, R+2} after a programmable number of cycles; a reference model lists
// every expected block input and SRAM write of a pass.
// -----------------------------------------------------------------------------
module tb_bf_expand_sched;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic         use_salt;
    logic [127:0] salt;
    int           dly;
    logic [31:0]  w0, w1, w2, w3;
  } vec_t;

  logic         clk;
  logic         reset_l;
  logic         start;
  logic         use_salt;
  logic [127:0] salt;
  logic         busy;
  logic         done;

  bf_expand_sched_if bus ();

  bf_expand_sched dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .start     (start),
    .use_salt  (use_salt),
    .salt      (salt),
    .busy      (busy),
    .done      (done),
    .sched_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  wr_t         exp_wr_q[$];
  logic [63:0] exp_fe_q[$];

  // monotonic event counters and per-pass bases
  int wr_tot = 0, wr_base = 0;
  int done_cnt = 0, done_base = 0;
  int busy_tot = 0, busy_base = 0;
  int fs_tot = 0, fs_base = 0;
  logic [31:0] first_wd[4];
  logic [11:0] first_wa[4];

  // feistel stub state
  int          fe_delay = 3;
  int          stub_cnt = 0;
  bit          stub_armed = 1'b0;
  logic [31:0] stub_l, stub_r;
  bit          dbl_mode = 1'b0;
  bit          dbl_pend = 1'b0;
  int          inject_req = 0, inject_ack = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: every block input and both writes of a full pass
  task automatic build_model(input logic us, input logic [127:0] sl);
    logic [31:0] cl, cr, il, ir, sw_l, sw_r;
    int a;
    wr_t w;
    exp_wr_q.delete();
    exp_fe_q.delete();
    cl = 32'd0;
    cr = 32'd0;
    for (int b = 0; b < 521; b++) begin
      if (!us) begin
        sw_l = 32'd0; sw_r = 32'd0;
      end else if (b % 2 == 0) begin
        sw_l = sl[127:96]; sw_r = sl[95:64];
      end else begin
        sw_l = sl[63:32]; sw_r = sl[31:0];
      end
      il = cl ^ sw_l;
      ir = cr ^ sw_r;
      exp_fe_q.push_back({il, ir});
      cl = il + 32'd1;
      cr = ir + 32'd2;
      a = (b < 9) ? (4000 + 2 * b) : (2 * (b - 9));
      w.addr = 12'(a);     w.data = cl; exp_wr_q.push_back(w);
      w.addr = 12'(a + 1); w.data = cr; exp_wr_q.push_back(w);
    end
  endtask

  // One clock: sample DUT on the falling edge, then update the feistel stub
  task automatic tick();
    wr_t w;
    logic [63:0] f;
    int idx;
    @(negedge clk);
    if (reset_l) begin
      if (busy) busy_tot++;
      if (done) done_cnt++;
      if (bus.fe_start) begin
        fs_tot++;
        if (exp_fe_q.size() == 0) chk("fe_extra_start", 64'd1, 64'd0);
        else begin
          f = exp_fe_q.pop_front();
          chk("fe_block_input", {bus.fe_L, bus.fe_R}, f);
        end
      end
      if (!bus.wr_cs_l) begin
        idx = wr_tot - wr_base;
        if (idx < 4) begin
          first_wd[idx] = bus.wr_data;
          first_wa[idx] = bus.wr_addr;
        end
        wr_tot++;
        if (exp_wr_q.size() == 0) chk("wr_extra", 64'd1, 64'd0);
        else begin
          w = exp_wr_q.pop_front();
          chk("wr_sel_we_addr_data",
              {18'd0, bus.sram_sel_fe, bus.wr_we_l, bus.wr_addr, bus.wr_data},
              {18'd0, 1'b0, 1'b0, w.addr, w.data});
        end
      end
    end
    // stub: results {L+1, R+2} after fe_delay cycles, optional spurious pulses
    bus.fe_done = 1'b0;
    if (dbl_pend) begin
      bus.fe_done = 1'b1;
      bus.fe_resultL = $urandom;
      bus.fe_resultR = $urandom;
      dbl_pend = 1'b0;
    end
    if (stub_armed) begin
      if (stub_cnt <= 1) begin
        bus.fe_done = 1'b1;
        bus.fe_resultL = stub_l + 32'd1;
        bus.fe_resultR = stub_r + 32'd2;
        stub_armed = 1'b0;
        dbl_pend = dbl_mode;
      end else stub_cnt--;
    end
    if (bus.fe_start && reset_l) begin
      stub_armed = 1'b1;
      stub_cnt = fe_delay;
      stub_l = bus.fe_L;
      stub_r = bus.fe_R;
    end
    if (inject_req != inject_ack) begin
      bus.fe_done = 1'b1;
      bus.fe_resultL = $urandom;
      bus.fe_resultR = $urandom;
      inject_ack = inject_req;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, bus.fe_start, bus.sram_sel_fe, bus.wr_cs_l, bus.wr_we_l}),
        64'(6'b000011));
    chk({tag, "_fe_lr"}, {bus.fe_L, bus.fe_R}, 64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
  endtask

  task automatic start_pass(input logic us, input logic [127:0] sl, input int dly);
    build_model(us, sl);
    fe_delay = dly;
    wr_base = wr_tot; done_base = done_cnt; busy_base = busy_tot; fs_base = fs_tot;
    use_salt = us;
    salt = sl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_pass(input string tag, input int exp_busy, input bit chk_first,
                             input logic [31:0] e0, e1, e2, e3);
    int cyc = 0;
    while (done_cnt == done_base && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
    tick();
    chk({tag, "_after_fin"}, 64'({busy, done}), 64'd0);
    repeat (4) tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_tot - busy_base), 64'(exp_busy));
    chk({tag, "_writes"}, 64'(wr_tot - wr_base), 64'd1042);
    chk({tag, "_model_left"}, 64'(exp_wr_q.size() + exp_fe_q.size()), 64'd0);
    if (chk_first) begin
      chk({tag, "_first_addr"}, 64'(first_wa[0]), 64'd4000);
      chk({tag, "_first4"}, {first_wd[0], first_wd[1]}, {e0, e1});
      chk({tag, "_second_pair"}, {first_wd[2], first_wd[3]}, {e2, e3});
    end
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] fl, fr;
    logic [127:0] rs;
    logic rus;
    int rd, viol, cyc;

    vecs[0] = '{1'b0, 128'd0, 3, 32'd1, 32'd2, 32'd2, 32'd4};
    vecs[1] = '{1'b1, 128'h1111_1111_2222_2222_3333_3333_4444_4444, 3,
                32'h1111_1112, 32'h2222_2224, 32'h2222_2222, 32'h6666_6662};
    vecs[2] = '{1'b0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D, 1,
                32'd1, 32'd2, 32'd2, 32'd4};
    vecs[3] = '{1'b1, {128{1'b1}}, 2, 32'd0, 32'd1, 32'd0, 32'd0};

    reset_l = 1'b0;
    start = 1'b0;
    use_salt = 1'b0;
    salt = 128'd0;
    bus.fe_done = 1'b0;
    bus.fe_resultL = 32'd0;
    bus.fe_resultR = 32'd0;
    tick();
    tick();
    check_reset("por");
    reset_l = 1'b1;
    tick();

    // table-driven full passes
    for (int i = 0; i < 4; i++) begin
      start_pass(vecs[i].use_salt, vecs[i].salt, vecs[i].dly);
      finish_pass($sformatf("vec%0d", i), 521 * (4 + vecs[i].dly) + 1, 1'b1,
                  vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
    end

    // spurious fe_done in IDLE and in every WR_L
    inject_req++;
    repeat (3) tick();
    dbl_mode = 1'b1;
    start_pass(1'b1, {$urandom, $urandom, $urandom, $urandom}, 2);
    finish_pass("spurious", 521 * 6 + 1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    dbl_mode = 1'b0;

    // randomized passes
    for (int i = 0; i < 2; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rus = 1'($urandom_range(0, 1));
      rd = $urandom_range(1, 4);
      start_pass(rus, rs, rd);
      finish_pass($sformatf("rand%0d", i), 521 * (4 + rd) + 1, 1'b0,
                  32'd0, 32'd0, 32'd0, 32'd0);
    end

    // long feistel stall on block 0, with start pulsed during WAIT
    start_pass(1'b1, {$urandom, $urandom, $urandom, $urandom}, 200);
    cyc = 0;
    while (fs_tot == fs_base && cyc < 50) begin tick(); cyc++; end
    chk("stall_fe_start_seen", 64'(fs_tot - fs_base), 64'd1);
    fe_delay = 3;
    fl = bus.fe_L;
    fr = bus.fe_R;
    viol = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      start = (i == 10) ? 1'b1 : 1'b0;
      if (bus.fe_L !== fl || bus.fe_R !== fr || bus.sram_sel_fe !== 1'b1 ||
          bus.wr_cs_l !== 1'b1 || bus.wr_we_l !== 1'b1 || bus.fe_start !== 1'b0)
        viol++;
    end
    start = 1'b0;
    chk("stall_hold_violations", 64'(viol), 64'd0);
    finish_pass("stall", 204 + 520 * 7 + 1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    // reset during WAIT of block 100, then a clean restart
    start_pass(1'b0, 128'd0, 3);
    cyc = 0;
    while (fs_tot - fs_base < 101 && cyc < 2000) begin tick(); cyc++; end
    chk("blk100_reached", 64'(fs_tot - fs_base), 64'd101);
    tick();
    #1 reset_l = 1'b0;
    #1 check_reset("midpass");
    repeat (3) tick();
    reset_l = 1'b1;
    repeat (2) tick();
    chk("post_reset_idle", 64'({busy, bus.sram_sel_fe, bus.wr_cs_l}), 64'(3'b001));
    start_pass(1'b0, 128'd0, 3);
    finish_pass("restart", 521 * 7 + 1, 1'b1, 32'd1, 32'd2, 32'd2, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
